// File: rtl/wordle_pkg.sv
// Shared constants, colour codes and sequencer state type for the guess scoring path.
package wordle_pkg;

  localparam int LETTER_W = 5;
  localparam int WORD_LEN = 5;
  localparam int TILE_W   = 7;

  localparam logic [1:0] COLOR_GRAY   = 2'b00;
  localparam logic [1:0] COLOR_GREEN  = 2'b01;
  localparam logic [1:0] COLOR_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Letter codes; 0 is a blank tile that never matches anything.
  localparam logic [LETTER_W-1:0] L_BLANK = 5'd0;
  localparam logic [LETTER_W-1:0] L_A = 5'd1;
  localparam logic [LETTER_W-1:0] L_B = 5'd2;
  localparam logic [LETTER_W-1:0] L_C = 5'd3;
  localparam logic [LETTER_W-1:0] L_D = 5'd4;
  localparam logic [LETTER_W-1:0] L_E = 5'd5;
  localparam logic [LETTER_W-1:0] L_F = 5'd6;
  localparam logic [LETTER_W-1:0] L_G = 5'd7;
  localparam logic [LETTER_W-1:0] L_H = 5'd8;
  localparam logic [LETTER_W-1:0] L_I = 5'd9;
  localparam logic [LETTER_W-1:0] L_J = 5'd10;
  localparam logic [LETTER_W-1:0] L_K = 5'd11;
  localparam logic [LETTER_W-1:0] L_L = 5'd12;
  localparam logic [LETTER_W-1:0] L_M = 5'd13;
  localparam logic [LETTER_W-1:0] L_N = 5'd14;
  localparam logic [LETTER_W-1:0] L_O = 5'd15;
  localparam logic [LETTER_W-1:0] L_P = 5'd16;
  localparam logic [LETTER_W-1:0] L_Q = 5'd17;
  localparam logic [LETTER_W-1:0] L_R = 5'd18;
  localparam logic [LETTER_W-1:0] L_S = 5'd19;
  localparam logic [LETTER_W-1:0] L_T = 5'd20;
  localparam logic [LETTER_W-1:0] L_U = 5'd21;
  localparam logic [LETTER_W-1:0] L_V = 5'd22;
  localparam logic [LETTER_W-1:0] L_W = 5'd23;
  localparam logic [LETTER_W-1:0] L_X = 5'd24;
  localparam logic [LETTER_W-1:0] L_Y = 5'd25;
  localparam logic [LETTER_W-1:0] L_Z = 5'd26;

endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest answer position holding a letter that has not yet been consumed.
module wordle_letter_match #(
  parameter int LETTER_W = 5
) (
  input  logic [LETTER_W-1:0]                     i_letter,
  input  logic [wordle_pkg::WORD_LEN*LETTER_W-1:0] i_answer,
  input  logic [wordle_pkg::WORD_LEN-1:0]          i_used,
  output logic                                     o_hit,
  output logic [wordle_pkg::WORD_LEN-1:0]          o_pos
);
  import wordle_pkg::*;

  // Scan high to low so the last assignment made is the lowest matching index.
  always_comb begin
    o_hit = 1'b0;
    o_pos = '0;
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (!i_used[j] && (i_letter != '0) &&
          (i_answer[j*LETTER_W +: LETTER_W] == i_letter)) begin
        o_hit    = 1'b1;
        o_pos    = '0;
        o_pos[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_eval_ctrl.sv
// Scores one guess against the answer a column per cycle (green pass, then yellow pass)
// and keeps guess count, win and game-over state for the game FSM.
module guess_eval_ctrl #(
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 5
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         new_game,
  input  logic                                         start,
  input  logic [wordle_pkg::WORD_LEN*LETTER_W-1:0]     guess,
  input  logic [wordle_pkg::WORD_LEN*LETTER_W-1:0]     answer,
  output logic                                         busy,
  output logic                                         done,
  output logic [wordle_pkg::WORD_LEN*(LETTER_W+2)-1:0] result,
  output logic                                         win,
  output logic                                         game_over,
  output logic [2:0]                                   guess_num
);
  import wordle_pkg::*;

  localparam int         TW       = LETTER_W + 2;
  localparam logic [2:0] LAST_COL = 3'(WORD_LEN - 1);
  localparam logic [2:0] MAX_N    = 3'(MAX_GUESSES);

  state_e                       r_state, w_next;
  logic [2:0]                   r_col;
  logic [WORD_LEN-1:0]          r_green, r_used;
  logic [WORD_LEN*LETTER_W-1:0] r_guess, r_answer;
  logic [WORD_LEN*TW-1:0]       r_shadow, r_result;
  logic                         r_done, r_win, r_over;
  logic [2:0]                   r_num;

  logic [LETTER_W-1:0] w_gl, w_al;
  logic                w_hit, w_accept, w_last;
  logic [WORD_LEN-1:0] w_pos;
  logic [2:0]          w_num_inc;
  logic [1:0]          w_color;

  assign w_gl      = r_guess[r_col*LETTER_W +: LETTER_W];
  assign w_al      = r_answer[r_col*LETTER_W +: LETTER_W];
  assign w_last    = (r_col == LAST_COL);
  // The done cycle still counts as busy, so a start there is dropped too.
  assign w_accept  = (r_state == ST_IDLE) && start && !new_game && !r_over && !r_done;
  assign w_num_inc = (r_num == MAX_N) ? r_num : r_num + 3'd1;

  wordle_letter_match #(.LETTER_W(LETTER_W)) u_match (
    .i_letter (w_gl),
    .i_answer (r_answer),
    .i_used   (r_used),
    .o_hit    (w_hit),
    .o_pos    (w_pos)
  );

  always_comb begin
    w_color = COLOR_GRAY;
    if (r_green[r_col])
      w_color = COLOR_GREEN;
    else if (w_hit)
      w_color = COLOR_YELLOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (new_game) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:   if (w_accept) w_next = ST_GREEN;
        ST_GREEN:  if (w_last)   w_next = ST_YELLOW;
        ST_YELLOW: if (w_last)   w_next = ST_REPORT;
        ST_REPORT: w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_green  <= '0;
      r_used   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_win    <= 1'b0;
      r_over   <= 1'b0;
      r_num    <= '0;
    end else begin
      r_done <= 1'b0;
      if (new_game) begin
        r_col    <= '0;
        r_green  <= '0;
        r_used   <= '0;
        r_result <= '0;
        r_win    <= 1'b0;
        r_over   <= 1'b0;
        r_num    <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_col   <= '0;
              r_green <= '0;
              r_used  <= '0;
            end
          end
          ST_GREEN: begin
            if ((w_gl == w_al) && (w_gl != '0)) begin
              r_green[r_col] <= 1'b1;
              r_used[r_col]  <= 1'b1;
            end
            r_col <= w_last ? 3'd0 : r_col + 3'd1;
          end
          ST_YELLOW: begin
            if (!r_green[r_col] && w_hit)
              r_used <= r_used | w_pos;
            r_col <= w_last ? 3'd0 : r_col + 3'd1;
          end
          ST_REPORT: begin
            r_done   <= 1'b1;
            r_result <= r_shadow;
            r_num    <= w_num_inc;
            if (&r_green) begin
              r_win  <= 1'b1;
              r_over <= 1'b1;
            end else if (w_num_inc == MAX_N) begin
              r_over <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Word copies and the tile shadow are fully rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_guess  <= guess;
      r_answer <= answer;
    end
    if (r_state == ST_YELLOW)
      r_shadow[r_col*TW +: TW] <= {w_color, w_gl};
  end

  assign busy      = (r_state != ST_IDLE) || r_done;
  assign done      = r_done;
  assign result    = r_result;
  assign win       = r_win;
  assign game_over = r_over;
  assign guess_num = r_num;

endmodule
